// File: rtl/muskbus_reader_if.sv
// MUSKBUS types and the bus-side channel bundle used by the line reader.
//
// Package MUSKBUS
//   req_t  : request channel  {bid, reqcyc, reqtag, req}
//   resp_t : response channel {respcyc, resptag, resp}
//   READ_MEM_TAG / WRITE_MEM_TAG : transaction tags sharing the response bus
//
// Interface muskbus_reader_if
//   bus_req     : request presented to the arbiter
//   bus_reqack  : arbiter accepted the request this cycle
//   bus_resp    : response beat from memory
//   bus_respack : beat consumed this cycle
//   modport master : the reader side (drives bus_req, bus_respack)
//   modport slave  : the arbiter/memory side
package MUSKBUS;
  typedef logic [7:0] tag_t;

  localparam tag_t READ_MEM_TAG  = 8'h01;
  localparam tag_t WRITE_MEM_TAG = 8'h02;

  typedef struct packed {
    logic        bid;
    logic        reqcyc;
    tag_t        reqtag;
    logic [63:0] req;
  } req_t;

  typedef struct packed {
    logic        respcyc;
    tag_t        resptag;
    logic [63:0] resp;
  } resp_t;
endpackage

interface muskbus_reader_if;
  MUSKBUS::req_t  bus_req;
  logic           bus_reqack;
  MUSKBUS::resp_t bus_resp;
  logic           bus_respack;

  modport master (
    output bus_req,
    input  bus_reqack,
    input  bus_resp,
    output bus_respack
  );

  modport slave (
    input  bus_req,
    output bus_reqack,
    output bus_resp,
    input  bus_respack
  );
endinterface

// File: rtl/muskbus_reader.sv
// Cache-line read initiator on the MUSKBUS.
// Bids for the bus with a READ_MEM_TAG request, then collects BEATS 64-bit
// response beats into one line and holds it for the client until the client
// drops its request.
//
// Ports
//   clk     : clock, rising edge
//   reset   : asynchronous, active-high
//   bus     : MUSKBUS channel bundle (master side)
//   reqcyc  : client read request, held until respcyc is seen
//   addr    : line address, sampled when leaving idle
//   respcyc : data holds the completed line
//   data    : assembled line, beat k at data[64*k +: 64]
//
// state     | meaning
// ----------+------------------------------------------------------------
// idle      | no transaction; waits for reqcyc
// init      | bidding for the bus with the latched address
// waiting   | request accepted, no beat received yet
// receiving | at least one beat captured, more to come
// serving   | line complete, presented to the client
// draining  | line complete but client already gone; one cycle to idle
module muskbus_reader #(
  parameter int BEATS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  muskbus_reader_if.master      bus,
  input  logic                  reqcyc,
  input  logic [63:0]           addr,
  output logic                  respcyc,
  output logic [0:64*BEATS-1]   data
);
  import MUSKBUS::*;

  localparam int BW = $clog2(BEATS + 1);

  typedef enum logic [2:0] {
    idle,
    init,
    waiting,
    receiving,
    serving,
    draining
  } state_t;

  state_t        state;
  logic [BW-1:0] beat_ff;
  logic [63:0]   addr_ff;

  logic beat_valid;
  logic accept;
  logic last_beat;

  // Beats are only taken once the arbiter has accepted the request; a
  // response coinciding with bus_reqack is still seen in init and dropped.
  assign beat_valid = bus.bus_resp.respcyc && (bus.bus_resp.resptag == READ_MEM_TAG);
  assign accept     = beat_valid && ((state == waiting) || (state == receiving));
  assign last_beat  = (beat_ff == BW'(BEATS - 1));

  assign bus.bus_respack = accept;

  // Decoded from registered state/address only, so the request is glitch
  // free and drops in the cycle after the arbiter's ack.
  assign bus.bus_req = (state == init)
                       ? req_t'{bid: 1'b1, reqcyc: 1'b1, reqtag: READ_MEM_TAG, req: addr_ff}
                       : req_t'('0);

  // Client may release in the serving cycle itself and see respcyc fall
  // immediately.
  assign respcyc = (state == serving) && reqcyc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= idle;
      beat_ff <= '0;
      addr_ff <= '0;
      data    <= '0;
    end else begin
      unique case (state)
        idle: begin
          if (reqcyc) begin
            addr_ff <= addr;
            beat_ff <= '0;
            state   <= init;
          end
        end

        init: begin
          if (bus.bus_reqack) begin
            state <= waiting;
          end
        end

        waiting, receiving: begin
          if (accept) begin
            for (int k = 0; k < BEATS; k++) begin
              if (beat_ff == BW'(k)) begin
                data[64*k +: 64] <= bus.bus_resp.resp;
              end
            end
            beat_ff <= beat_ff + BW'(1);
            // The bus transfer cannot be cancelled, so an abandoned request
            // still runs to the last beat and only then is discarded.
            if (last_beat) begin
              state <= reqcyc ? serving : draining;
            end else begin
              state <= receiving;
            end
          end
        end

        serving: begin
          if (!reqcyc) begin
            beat_ff <= '0;
            state   <= idle;
          end
        end

        draining: begin
          beat_ff <= '0;
          state   <= idle;
        end

        default: begin
          state <= idle;
        end
      endcase
    end
  end
endmodule
